// File: rtl/uart_pkg.sv
// Shared register map, STAT bit positions and scheduler state encoding
// for the UART polling scheduler.
package uart_pkg;

    localparam logic [3:0] ADDR_RX   = 4'h0;
    localparam logic [3:0] ADDR_TX   = 4'h4;
    localparam logic [3:0] ADDR_STAT = 4'h8;
    localparam logic [3:0] ADDR_CTRL = 4'hC;

    localparam int STAT_RXV = 0;
    localparam int STAT_TXF = 3;
    localparam int STAT_OVR = 5;
    localparam int STAT_PAR = 7;

    localparam logic [31:0] CTRL_RST_FIFOS = 32'h0000_0003;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_POLL,
        ST_DECIDE,
        ST_RD_RX,
        ST_WR_TX,
        ST_GAP,
        ST_FAULT
    } uart_sched_state_t;

endpackage

// File: rtl/uart_sched.sv
// Polling scheduler: sequences STAT polls, RX reads and TX writes to the
// UART wrapper and tracks sticky line/bus/timeout errors.
module uart_sched
    import uart_pkg::*;
#(
    parameter int POLL_GAP = 16,
    parameter int TIMEOUT  = 1024,
    parameter int CNT_W    = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             tx_valid_i,
    input  logic [7:0]       tx_data_i,
    output logic             tx_ready_o,
    output logic             rx_valid_o,
    output logic [7:0]       rx_data_o,
    input  logic             rx_ready_i,
    output logic             uart_wr_valid_o,
    output logic [3:0]       uart_wr_addr_o,
    output logic [31:0]      uart_wr_data_o,
    input  logic             uart_wr_ready_i,
    input  logic             uart_wr_err_i,
    output logic             uart_rd_req_o,
    output logic [3:0]       uart_rd_addr_o,
    input  logic             uart_rd_valid_i,
    input  logic [31:0]      uart_rd_data_i,
    input  logic             uart_rd_err_i,
    input  logic             err_clr_i,
    output logic [2:0]       line_err_o,
    output logic             bus_err_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] ovr_cnt_o
);

    localparam int MAXC = (TIMEOUT > POLL_GAP) ? TIMEOUT : POLL_GAP;
    localparam int CW   = $clog2(MAXC) + 1;
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(POLL_GAP - 1);

    uart_sched_state_t state_q, state_d;
    logic             req_q, req_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             prio_q, prio_d;
    logic             srx_q, srx_d;
    logic             stxf_q, stxf_d;
    logic [7:0]       txb_q, txb_d;
    logic             rxv_q, rxv_d;
    logic [7:0]       rxd_q, rxd_d;
    logic [2:0]       line_q, line_d;
    logic             bus_q, bus_d;
    logic             to_q, to_d;
    logic [CNT_W-1:0] ovr_q, ovr_d;

    logic is_wr_st;
    logic resp;
    logic rerr;
    logic rx_elig;
    logic tx_elig;
    logic take_tx;
    logic tx_rdy;
    logic unused_rd;

    assign unused_rd = ^uart_rd_data_i[31:8];

    assign is_wr_st = (state_q == ST_INIT) || (state_q == ST_WR_TX);
    assign resp     = req_q & (is_wr_st ? uart_wr_ready_i : uart_rd_valid_i);
    assign rerr     = is_wr_st ? uart_wr_err_i : uart_rd_err_i;
    assign rx_elig  = srx_q & ~rxv_q;
    assign tx_elig  = tx_valid_i & ~stxf_q;
    // prio_q=1 means TX wins the next tie
    assign take_tx  = tx_elig & (~rx_elig | prio_q);

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        cnt_d   = cnt_q;
        prio_d  = prio_q;
        srx_d   = srx_q;
        stxf_d  = stxf_q;
        txb_d   = txb_q;
        rxv_d   = rxv_q;
        rxd_d   = rxd_q;
        line_d  = line_q;
        bus_d   = bus_q;
        to_d    = to_q;
        ovr_d   = ovr_q;
        tx_rdy  = 1'b0;

        if (rxv_q && rx_ready_i) rxv_d = 1'b0;
        if (err_clr_i) begin
            line_d = '0;
            bus_d  = 1'b0;
            to_d   = 1'b0;
        end

        unique case (state_q)
            ST_INIT, ST_POLL, ST_RD_RX, ST_WR_TX: begin
                if (!req_q) begin
                    req_d = 1'b1;
                    cnt_d = '0;
                end else if (resp) begin
                    req_d = 1'b0;
                    if (rerr) begin
                        bus_d   = 1'b1;
                        state_d = ST_FAULT;
                    end else if (state_q == ST_POLL) begin
                        srx_d   = uart_rd_data_i[STAT_RXV];
                        stxf_d  = uart_rd_data_i[STAT_TXF];
                        line_d  = line_d | uart_rd_data_i[STAT_PAR:STAT_OVR];
                        if (uart_rd_data_i[STAT_OVR] && (ovr_q != '1))
                            ovr_d = ovr_q + 1'b1;
                        state_d = ST_DECIDE;
                    end else if (state_q == ST_RD_RX) begin
                        rxd_d   = uart_rd_data_i[7:0];
                        rxv_d   = 1'b1;
                        state_d = ST_POLL;
                    end else begin
                        state_d = ST_POLL;
                    end
                end else if (cnt_q == TO_LAST) begin
                    req_d   = 1'b0;
                    to_d    = 1'b1;
                    state_d = ST_FAULT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DECIDE: begin
                if (rx_elig && tx_elig) prio_d = ~prio_q;
                if (take_tx) begin
                    tx_rdy  = 1'b1;
                    txb_d   = tx_data_i;
                    state_d = ST_WR_TX;
                end else if (rx_elig) begin
                    state_d = ST_RD_RX;
                end else begin
                    cnt_d   = '0;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) state_d = ST_POLL;
                else cnt_d = cnt_q + 1'b1;
            end
            ST_FAULT: begin
                if (err_clr_i) begin
                    ovr_d   = '0;
                    state_d = ST_INIT;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= ST_INIT;
            req_q   <= 1'b0;
            cnt_q   <= '0;
            prio_q  <= 1'b0;
            srx_q   <= 1'b0;
            stxf_q  <= 1'b0;
            txb_q   <= '0;
            rxv_q   <= 1'b0;
            rxd_q   <= '0;
            line_q  <= '0;
            bus_q   <= 1'b0;
            to_q    <= 1'b0;
            ovr_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
            prio_q  <= prio_d;
            srx_q   <= srx_d;
            stxf_q  <= stxf_d;
            txb_q   <= txb_d;
            rxv_q   <= rxv_d;
            rxd_q   <= rxd_d;
            line_q  <= line_d;
            bus_q   <= bus_d;
            to_q    <= to_d;
            ovr_q   <= ovr_d;
        end
    end

    // Reset drops any live request in the same cycle
    assign uart_wr_valid_o = rst_n_i & req_q & is_wr_st;
    assign uart_rd_req_o   = rst_n_i & req_q & ~is_wr_st;
    assign tx_ready_o      = rst_n_i & tx_rdy;

    always_comb begin
        uart_wr_addr_o = '0;
        uart_wr_data_o = '0;
        uart_rd_addr_o = '0;
        if (uart_wr_valid_o) begin
            if (state_q == ST_INIT) begin
                uart_wr_addr_o = ADDR_CTRL;
                uart_wr_data_o = CTRL_RST_FIFOS;
            end else begin
                uart_wr_addr_o = ADDR_TX;
                uart_wr_data_o = {24'h0, txb_q};
            end
        end
        if (uart_rd_req_o)
            uart_rd_addr_o = (state_q == ST_POLL) ? ADDR_STAT : ADDR_RX;
    end

    assign rx_valid_o = rxv_q;
    assign rx_data_o  = rxd_q;
    assign line_err_o = line_q;
    assign bus_err_o  = bus_q;
    assign timeout_o  = to_q;
    assign ovr_cnt_o  = ovr_q;

endmodule
